// File: rtl/op_issuer.sv
// Request issuer: accepts ADD/NOOP/illegal commands, drives a registered compute unit for ADD,
// and buffers responses in a small FIFO. Optional counters behind OP_ISSUER_STATS_EN.
module op_issuer #(
    parameter int DATA_W     = 32,
    parameter int CMD_W      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CMD_W-1:0]  req_cmd,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    output logic              alu_enable,
    output logic              alu_reset,
    output logic [CMD_W-1:0]  alu_cmd,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [CMD_W-1:0]  rsp_cmd,
    output logic              rsp_err
`ifdef OP_ISSUER_STATS_EN
    ,
    output logic [15:0]       stat_issued,
    output logic [15:0]       stat_errors
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CMD_W-1:0] CMD_NOOP = CMD_W'(0);
    localparam logic [CMD_W-1:0] CMD_ADD  = CMD_W'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
    logic [CMD_W-1:0]  mem_cmd_q  [FIFO_DEPTH];
    logic              mem_err_q  [FIFO_DEPTH];

    logic              full, empty, accept, push, pop, issuing;
    logic [DATA_W-1:0] push_data;
    logic [CMD_W-1:0]  push_cmd;
    logic              push_err;

    always_comb begin
        full      = (count_q == CNT_W'(FIFO_DEPTH));
        empty     = (count_q == '0);
        req_ready = (state_q == IDLE) && !full && !reset;
        accept    = req_valid && req_ready;
        pop       = !empty && rsp_ready;

        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        push      = 1'b0;
        push_data = '0;
        push_cmd  = req_cmd;
        push_err  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_cmd == CMD_ADD) begin
                        state_d = ISSUE;
                        a_d     = req_a;
                        b_d     = req_b;
                    end else begin
                        push     = 1'b1;
                        push_err = (req_cmd != CMD_NOOP);
                    end
                end
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                // ADD was only accepted with a free slot, so this push always fits
                push      = 1'b1;
                push_data = alu_out;
                push_cmd  = CMD_ADD;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count governs validity and outputs are gated when empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= push_data;
            mem_cmd_q[wr_ptr_q]  <= push_cmd;
            mem_err_q[wr_ptr_q]  <= push_err;
        end
    end

    always_comb begin
        issuing    = (state_q == ISSUE) && !reset;
        alu_reset  = reset;
        alu_enable = reset || issuing;
        alu_cmd    = issuing ? CMD_ADD : CMD_NOOP;
        alu_in1    = issuing ? a_q : '0;
        alu_in2    = issuing ? b_q : '0;

        rsp_valid  = !empty;
        rsp_data   = empty ? '0       : mem_data_q[rd_ptr_q];
        rsp_cmd    = empty ? CMD_NOOP : mem_cmd_q[rd_ptr_q];
        rsp_err    = empty ? 1'b0     : mem_err_q[rd_ptr_q];
    end

`ifdef OP_ISSUER_STATS_EN
    logic [15:0] stat_issued_q, stat_issued_d, stat_errors_q, stat_errors_d;

    always_comb begin
        stat_issued_d = stat_issued_q;
        stat_errors_d = stat_errors_q;
        if (state_q == ISSUE && stat_issued_q != 16'hFFFF)
            stat_issued_d = stat_issued_q + 16'd1;
        if (accept && req_cmd != CMD_ADD && req_cmd != CMD_NOOP && stat_errors_q != 16'hFFFF)
            stat_errors_d = stat_errors_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_issued_q <= '0;
            stat_errors_q <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_errors_q <= stat_errors_d;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_errors = stat_errors_q;
`endif

endmodule

// File: tb/tb_op_issuer.sv
// Directed bench for op_issuer with a registered ADD compute-unit model.
module tb_op_issuer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready;
    logic [1:0]  req_cmd;
    logic [31:0] req_a, req_b;
    logic        alu_enable, alu_reset;
    logic [1:0]  alu_cmd;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_cmd;
    logic        rsp_err;
`ifdef OP_ISSUER_STATS_EN
    logic [15:0] stat_issued, stat_errors;
`endif

    int checks = 0;
    int errors = 0;
    logic saw30 = 1'b0;

    op_issuer dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_a(req_a), .req_b(req_b),
        .alu_enable(alu_enable), .alu_reset(alu_reset), .alu_cmd(alu_cmd),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_cmd(rsp_cmd), .rsp_err(rsp_err)
`ifdef OP_ISSUER_STATS_EN
        , .stat_issued(stat_issued), .stat_errors(stat_errors)
`endif
    );

    always #5 clk = ~clk;

    // Compute unit: registered sum, cleared by alu_reset
    always @(posedge clk) begin
        if (alu_reset) alu_out <= 32'd0;
        else if (alu_enable && alu_cmd == 2'd1) alu_out <= alu_in1 + alu_in2;
    end

    always @(negedge clk) if (rsp_valid && rsp_data == 32'd30) saw30 = 1'b1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp_v);
    endtask

    int idx, got;
    logic prev_stall, acc;
    logic [31:0] held;
    logic [31:0] exp_seq [3];

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_cmd = 2'd0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        tick();
        chk("rst_alu_reset", 32'(alu_reset), 32'd1);
        chk("rst_alu_enable", 32'(alu_enable), 32'd1);
        chk("rst_alu_cmd", 32'(alu_cmd), 32'd0);
        chk("rst_alu_in1", alu_in1, 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_rsp_data", rsp_data, 32'd0);
        chk("post_rsp_err", 32'(rsp_err), 32'd0);
        chk("post_rsp_cmd", 32'(rsp_cmd), 32'd0);
        chk("post_alu_enable", 32'(alu_enable), 32'd0);
        chk("post_alu_reset", 32'(alu_reset), 32'd0);
        chk("post_req_ready", 32'(req_ready), 32'd1);

        // ADD 5 + -3: cycle 1 ISSUE, cycle 2 CAPTURE, cycle 3 response
        req_valid = 1'b1; req_cmd = 2'd1; req_a = 32'd5; req_b = 32'hFFFF_FFFD;
        tick();
        req_valid = 1'b0;
        chk("add_issue_en", 32'(alu_enable), 32'd1);
        chk("add_issue_cmd", 32'(alu_cmd), 32'd1);
        chk("add_in1", alu_in1, 32'd5);
        chk("add_in2", alu_in2, 32'hFFFF_FFFD);
        chk("add_busy_ready", 32'(req_ready), 32'd0);
        chk("add_c1_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("add_cap_en", 32'(alu_enable), 32'd0);
        chk("add_cap_cmd", 32'(alu_cmd), 32'd0);
        chk("add_cap_in1", alu_in1, 32'd0);
        chk("add_c2_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("add_c3_valid", 32'(rsp_valid), 32'd1);
        chk("add_data", rsp_data, 32'd2);
        chk("add_err", 32'(rsp_err), 32'd0);
        chk("add_cmd", 32'(rsp_cmd), 32'd1);
        chk("add_en_after", 32'(alu_enable), 32'd0);
        tick();
        chk("add_popped", 32'(rsp_valid), 32'd0);

        // Wrap-around sum
        req_valid = 1'b1; req_cmd = 2'd1; req_a = 32'h7FFF_FFFF; req_b = 32'd1;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("wrap_valid", 32'(rsp_valid), 32'd1);
        chk("wrap_data", rsp_data, 32'h8000_0000);
        tick();
        chk("wrap_popped", 32'(rsp_valid), 32'd0);

        // Fill FIFO with NOOPs while stalled
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_cmd = 2'd0; req_a = 32'd9; req_b = 32'd9;
        for (int i = 0; i < 4; i++) begin
            chk("noop_ready", 32'(req_ready), 32'd1);
            tick();
        end
        chk("full_ready", 32'(req_ready), 32'd0);
        chk("full_valid", 32'(rsp_valid), 32'd1);
        chk("noop_data", rsp_data, 32'd0);
        chk("noop_cmd", 32'(rsp_cmd), 32'd0);
        tick();
        chk("full_hold_ready", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        tick();
        // Pop at the last edge did not allow acceptance on that same edge
        chk("after_pop_ready", 32'(req_ready), 32'd1);
        chk("after_pop_valid", 32'(rsp_valid), 32'd1);
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("drain_valid", 32'(rsp_valid), 32'd1);
            chk("drain_data", rsp_data, 32'd0);
            tick();
        end
        chk("drained", 32'(rsp_valid), 32'd0);

        // Illegal opcode
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_cmd = 2'd3; req_a = 32'd7; req_b = 32'd7;
        tick();
        req_valid = 1'b0;
        chk("ill_valid", 32'(rsp_valid), 32'd1);
        chk("ill_err", 32'(rsp_err), 32'd1);
        chk("ill_cmd", 32'(rsp_cmd), 32'd3);
        chk("ill_data", rsp_data, 32'd0);
        chk("ill_alu_en", 32'(alu_enable), 32'd0);
        chk("ill_idle_ready", 32'(req_ready), 32'd1);
`ifdef OP_ISSUER_STATS_EN
        chk("stat_errors", 32'(stat_errors), 32'd1);
        chk("stat_issued", 32'(stat_issued), 32'd2);
`endif
        rsp_ready = 1'b1;
        tick();
        chk("ill_popped", 32'(rsp_valid), 32'd0);

        // Reset during CAPTURE of 10+20 with two buffered responses
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_cmd = 2'd0;
        tick();
        tick();
        req_cmd = 2'd1; req_a = 32'd10; req_b = 32'd20;
        tick();
        req_valid = 1'b0;
        chk("mid_issue_en", 32'(alu_enable), 32'd1);
        tick();
        chk("mid_cap_en", 32'(alu_enable), 32'd0);
        chk("mid_buffered", 32'(rsp_valid), 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        #1;
        chk("mid_idle_ready", 32'(req_ready), 32'd1);
        chk("mid_alu_en", 32'(alu_enable), 32'd0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_no_resp", 32'(rsp_valid), 32'd0);

        // Back-to-back ADDs with rsp_ready toggling every cycle
        exp_seq[0] = 32'd2; exp_seq[1] = 32'd4; exp_seq[2] = 32'd6;
        idx = 0; got = 0; prev_stall = 1'b0; held = '0;
        rsp_ready = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
            rsp_ready = ~rsp_ready;
            req_valid = (idx < 3);
            req_cmd   = 2'd1;
            req_a     = 32'(idx + 1);
            req_b     = 32'(idx + 1);
            #0;
            if (prev_stall) chk("b2b_stable", rsp_data, held);
            if (rsp_valid && rsp_ready) begin
                chk("b2b_data", rsp_data, exp_seq[got]);
                got++;
            end
            prev_stall = rsp_valid && !rsp_ready;
            held = rsp_data;
            acc = req_valid && req_ready;
            tick();
            if (acc) idx++;
        end
        req_valid = 1'b0;
        chk("b2b_count", 32'(got), 32'd3);

        chk("no_sum30", 32'(saw30), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
